// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM initialisation checker: command encodings,
// checker states and error codes.
package sdram_pkg;

  // {ras_n, cas_n, we_n} encodings with cs_n low; cs_n high is always a deselect
  localparam logic [3:0] CMD_LMR = 4'b0000;
  localparam logic [3:0] CMD_AR  = 4'b0001;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_BST = 4'b0110;
  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [6:0] {
    ST_PWRUP    = 7'b0000001,
    ST_WAIT_PRE = 7'b0000010,
    ST_WAIT_AR  = 7'b0000100,
    ST_REFRESH  = 7'b0001000,
    ST_WAIT_MRD = 7'b0010000,
    ST_DONE     = 7'b0100000,
    ST_ERROR    = 7'b1000000
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_EARLY   = 3'd1;
  localparam logic [2:0] ERR_TIMING  = 3'd2;
  localparam logic [2:0] ERR_ORDER   = 3'd3;
  localparam logic [2:0] ERR_ILLEGAL = 3'd4;
  localparam logic [2:0] ERR_NOT_ALL = 3'd5;
  localparam logic [2:0] ERR_BANK    = 3'd6;

endpackage

// File: rtl/sdram_cmd_decode.sv
// Combinational decode of the SDRAM command pins into one-hot command classes
// as seen during the initialisation sequence.
module sdram_cmd_decode
  import sdram_pkg::*;
(
  input  logic [3:0] i_cmd,
  input  logic       i_a10,
  output logic       o_is_nop,
  output logic       o_is_pre,
  output logic       o_is_pre_all,
  output logic       o_is_ar,
  output logic       o_is_lmr,
  output logic       o_is_illegal
);

  always_comb begin
    o_is_nop     = 1'b0;
    o_is_pre     = 1'b0;
    o_is_ar      = 1'b0;
    o_is_lmr     = 1'b0;
    o_is_illegal = 1'b0;
    if (i_cmd[3]) begin
      o_is_nop = 1'b1;
    end else begin
      case (i_cmd)
        CMD_NOP: o_is_nop = 1'b1;
        CMD_PRE: o_is_pre = 1'b1;
        CMD_AR:  o_is_ar  = 1'b1;
        CMD_LMR: o_is_lmr = 1'b1;
        CMD_ACT, CMD_RD, CMD_WR, CMD_BST: o_is_illegal = 1'b1;
        default: o_is_illegal = 1'b1;
      endcase
    end
    o_is_pre_all = o_is_pre & i_a10;
  end

endmodule

// File: rtl/sdram_init_checker.sv
// Passive monitor of the SDRAM power-up initialisation sequence: checks order
// and NOP spacing, captures the mode register, and reports done or first error.
module sdram_init_checker
  import sdram_pkg::*;
#(
  parameter int POWERUP_CYC = 20000,
  parameter int T_RP        = 2,
  parameter int T_RFC       = 7,
  parameter int T_MRD       = 3,
  parameter int AREF_MIN    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  i_cmd,
  input  logic [1:0]  i_ba,
  input  logic [12:0] i_addr,
  output logic        o_init_done,
  output logic [12:0] o_mode_reg,
  output logic [3:0]  o_aref_cnt,
  output logic        o_err,
  output logic [2:0]  o_err_code,
  output logic        o_err_pulse
);

  localparam int PW = $clog2(POWERUP_CYC + 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [PW-1:0] r_pwr_cnt;
  logic [7:0]    r_nop_cnt;
  logic [3:0]    r_aref_cnt;
  logic [12:0]   r_mode_reg;
  logic          r_init_done;
  logic          r_err;
  logic [2:0]    r_err_code;
  logic          r_err_pulse;

  logic       w_is_nop, w_is_pre, w_is_pre_all, w_is_ar, w_is_lmr, w_is_illegal;
  logic       w_err_set;
  logic [2:0] w_err_val;
  logic       w_ar_inc;
  logic       w_lmr_cap;
  logic       w_rp_short, w_rfc_short;

  sdram_cmd_decode u_decode (
    .i_cmd        (i_cmd),
    .i_a10        (i_addr[10]),
    .o_is_nop     (w_is_nop),
    .o_is_pre     (w_is_pre),
    .o_is_pre_all (w_is_pre_all),
    .o_is_ar      (w_is_ar),
    .o_is_lmr     (w_is_lmr),
    .o_is_illegal (w_is_illegal)
  );

  assign w_rp_short  = !w_is_nop && (r_nop_cnt < 8'(T_RP));
  assign w_rfc_short = !w_is_nop && (r_nop_cnt < 8'(T_RFC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_PWRUP;
    else        r_state <= w_next_state;
  end

  // Timing violations are tested before ordering so an early command reports code 2
  always_comb begin
    w_next_state = r_state;
    w_err_set    = 1'b0;
    w_err_val    = ERR_NONE;
    w_ar_inc     = 1'b0;
    w_lmr_cap    = 1'b0;
    case (r_state)
      ST_PWRUP: begin
        if (!w_is_nop) begin
          w_err_set = 1'b1;
          w_err_val = ERR_EARLY;
        end else if (r_pwr_cnt == PW'(POWERUP_CYC - 1)) begin
          w_next_state = ST_WAIT_PRE;
        end
      end
      ST_WAIT_PRE: begin
        if (w_is_pre_all) begin
          w_next_state = ST_WAIT_AR;
        end else if (w_is_pre) begin
          w_err_set = 1'b1;
          w_err_val = ERR_NOT_ALL;
        end else if (w_is_ar || w_is_lmr) begin
          w_err_set = 1'b1;
          w_err_val = ERR_ORDER;
        end else if (w_is_illegal) begin
          w_err_set = 1'b1;
          w_err_val = ERR_ILLEGAL;
        end
      end
      ST_WAIT_AR: begin
        if (w_is_illegal) begin
          w_err_set = 1'b1;
          w_err_val = ERR_ILLEGAL;
        end else if (w_rp_short) begin
          w_err_set = 1'b1;
          w_err_val = ERR_TIMING;
        end else if (w_is_ar) begin
          w_next_state = ST_REFRESH;
          w_ar_inc     = 1'b1;
        end else if (w_is_pre || w_is_lmr) begin
          w_err_set = 1'b1;
          w_err_val = ERR_ORDER;
        end
      end
      ST_REFRESH: begin
        if (w_rfc_short) begin
          w_err_set = 1'b1;
          w_err_val = ERR_TIMING;
        end else if (w_is_ar) begin
          w_ar_inc = 1'b1;
        end else if (w_is_lmr) begin
          if (r_aref_cnt < 4'(AREF_MIN)) begin
            w_err_set = 1'b1;
            w_err_val = ERR_ORDER;
          end else if (i_ba != 2'b00) begin
            w_err_set = 1'b1;
            w_err_val = ERR_BANK;
          end else begin
            w_lmr_cap    = 1'b1;
            w_next_state = ST_WAIT_MRD;
          end
        end else if (w_is_pre) begin
          w_err_set = 1'b1;
          w_err_val = ERR_ORDER;
        end else if (w_is_illegal) begin
          w_err_set = 1'b1;
          w_err_val = ERR_ILLEGAL;
        end
      end
      ST_WAIT_MRD: begin
        if (!w_is_nop) begin
          w_err_set = 1'b1;
          w_err_val = ERR_TIMING;
        end else if (r_nop_cnt == 8'(T_MRD - 1)) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE:  w_next_state = ST_DONE;
      ST_ERROR: w_next_state = ST_ERROR;
      default:  w_next_state = ST_PWRUP;
    endcase
    if (w_err_set) w_next_state = ST_ERROR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwr_cnt   <= '0;
      r_nop_cnt   <= '0;
      r_aref_cnt  <= '0;
      r_mode_reg  <= '0;
      r_init_done <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_err_pulse <= 1'b0;
    end else begin
      if (!w_is_nop)                r_nop_cnt <= '0;
      else if (r_nop_cnt != 8'hFF)  r_nop_cnt <= r_nop_cnt + 8'd1;
      if (r_state == ST_PWRUP && w_is_nop) r_pwr_cnt <= r_pwr_cnt + 1'b1;
      if (w_ar_inc && r_aref_cnt != 4'hF)  r_aref_cnt <= r_aref_cnt + 4'd1;
      if (w_lmr_cap) r_mode_reg <= i_addr;
      r_init_done <= (w_next_state == ST_DONE);
      r_err_pulse <= w_err_set;
      if (w_err_set) begin
        r_err      <= 1'b1;
        r_err_code <= w_err_val;
      end
    end
  end

  assign o_init_done = r_init_done;
  assign o_mode_reg  = r_mode_reg;
  assign o_aref_cnt  = r_aref_cnt;
  assign o_err       = r_err;
  assign o_err_code  = r_err_code;
  assign o_err_pulse = r_err_pulse;

endmodule
